stopwatch_ctrl: RTL and testbench

Timing and control sequencer for the stopwatch `count` datapath. It derives single-cycle count and adjust enables from the master clock and turns the raw pause and clear buttons into clean one-cycle events. It keeps the run/pause state and gates the enables according to the adjust and select switches. It sits between the board I/O and `count`, which it drives entirely through enables, with no derived clocks.

---
 rtl/stopwatch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: tick prescalers, button conditioning and run/pause control.
// Build option: define STOPWATCH_DEBOUNCE_EN to insert the button debouncers.
module stopwatch_ctrl #(
    parameter int unsigned DIV_1HZ    = 100_000_000,
    parameter int unsigned DIV_ADJ    = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pause,
    input  logic btn_clear,
    input  logic adjust,
    input  logic select,
    output logic cnt_en,
    output logic adj_en,
    output logic adj_sel,
    output logic clr,
    output logic running,
    output logic blink
);

    localparam int unsigned P1_W = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
    localparam int unsigned PA_W = (DIV_ADJ > 1) ? $clog2(DIV_ADJ) : 1;
    localparam logic [P1_W-1:0] P1_LAST = P1_W'(DIV_1HZ - 1);
    localparam logic [PA_W-1:0] PA_LAST = PA_W'(DIV_ADJ - 1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_PAUSE = 1'b1
    } state_e;

    // raw input bit order: 0 pause, 1 clear, 2 adjust, 3 select
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic            adj_sel_q, adj_sel_d;
    logic [1:0]      lvl;
    logic [1:0]      lvl_prev_q, lvl_prev_d;
    logic            pause_evt, clear_evt;
    logic            adj_on;
    logic            p1_term, pa_term;
    logic [P1_W-1:0] p1_q, p1_d;
    logic [PA_W-1:0] pa_q, pa_d;
    logic            cnt_en_q, cnt_en_d;
    logic            adj_en_q, adj_en_d;
    logic            clr_q, clr_d;
    logic            blink_q, blink_d;
    state_e          state_q, state_d;

    // two-stage synchronizers plus the extra stage on select
    always_comb begin
        sync1_d   = {select, adjust, btn_clear, btn_pause};
        sync2_d   = sync1_q;
        adj_sel_d = sync2_q[3];
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]            deb_q, deb_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // level only follows the synchronized button after a stable run
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    // debouncer state
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign lvl = deb_q;
`else
    assign lvl = sync2_q[1:0];
`endif

    // rising edges of the clean button levels become one-cycle events
    always_comb begin
        lvl_prev_d = lvl;
        pause_evt  = lvl[0] & ~lvl_prev_q[0];
        clear_evt  = lvl[1] & ~lvl_prev_q[1];
    end

    // run/pause state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // a pause event flips between run and pause
    always_comb begin
        state_d = state_q;
        if (pause_evt) begin
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end
    end

    // state decode
    always_comb begin
        running = (state_q == S_RUN);
    end

    // prescalers free-run; enables are gated at the terminal count
    always_comb begin
        adj_on   = sync2_q[2];
        p1_term  = (p1_q == P1_LAST);
        pa_term  = (pa_q == PA_LAST);
        p1_d     = (clear_evt || p1_term) ? '0 : p1_q + 1'b1;
        pa_d     = (clear_evt || pa_term) ? '0 : pa_q + 1'b1;
        cnt_en_d = p1_term & running & ~adj_on;
        adj_en_d = pa_term & running & adj_on;
        blink_d  = adj_on ? (blink_q ^ pa_term) : 1'b0;
        clr_d    = clear_evt;
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            adj_sel_q  <= 1'b0;
            lvl_prev_q <= '0;
            p1_q       <= '0;
            pa_q       <= '0;
            cnt_en_q   <= 1'b0;
            adj_en_q   <= 1'b0;
            clr_q      <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            adj_sel_q  <= adj_sel_d;
            lvl_prev_q <= lvl_prev_d;
            p1_q       <= p1_d;
            pa_q       <= pa_d;
            cnt_en_q   <= cnt_en_d;
            adj_en_q   <= adj_en_d;
            clr_q      <= clr_d;
            blink_q    <= blink_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign adj_en  = adj_en_q;
    assign adj_sel = adj_sel_q;
    assign clr     = clr_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus random buttons/switches,
// every cycle compared with a behavioural model of the controller.
module tb_stopwatch_ctrl;

    localparam int DIV1 = 8;
    localparam int DIVA = 4;
    localparam int DEB  = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    // edges from a raw press to the running/clr change
    localparam int LAT = DEB_ON ? DEB + 3 : 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_pause = 1'b0;
    logic btn_clear = 1'b0;
    logic adjust = 1'b0;
    logic select = 1'b0;
    logic cnt_en, adj_en, adj_sel, clr, running, blink;

    int n_chk = 0;
    int n_err = 0;

    stopwatch_ctrl #(
        .DIV_1HZ   (DIV1),
        .DIV_ADJ   (DIVA),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_pause(btn_pause),
        .btn_clear(btn_clear),
        .adjust   (adjust),
        .select   (select),
        .cnt_en   (cnt_en),
        .adj_en   (adj_en),
        .adj_sel  (adj_sel),
        .clr      (clr),
        .running  (running),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    // behavioural model: inputs seen through a 2-deep delay line,
    // tick phase = cycles since reset/clear modulo the divider
    bit [3:0] m_s1, m_s2;
    bit [1:0] m_lvl, m_prev;
    int       m_run [2];
    bit       m_paused, m_adj_sel;
    bit       m_cnt_en, m_adj_en, m_clr, m_blink;
    int       m_since;

    always @(posedge clk) begin : model
        bit [1:0] lv, ev;
        bit       adj, t1, ta;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_paused = 0; m_adj_sel = 0; m_since = 0;
            m_cnt_en = 0; m_adj_en = 0; m_clr = 0; m_blink = 0;
        end else begin
            lv  = DEB_ON ? m_lvl : m_s2[1:0];
            ev  = lv & ~m_prev;
            adj = m_s2[2];
            t1  = (m_since % DIV1) == DIV1 - 1;
            ta  = (m_since % DIVA) == DIVA - 1;
            m_cnt_en = t1 && !m_paused && !adj;
            m_adj_en = ta && !m_paused && adj;
            m_blink  = adj ? (m_blink ^ ta) : 1'b0;
            m_clr    = ev[1];
            m_paused = m_paused ^ ev[0];
            m_since  = ev[1] ? 0 : m_since + 1;
            m_prev   = lv;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_adj_sel = m_s2[3];
            m_s2 = m_s1;
            m_s1 = {select, adjust, btn_clear, btn_pause};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one cycle and compare every output with the model
    task automatic tick();
        @(negedge clk);
        chk("cnt_en",  32'(cnt_en),  32'(m_cnt_en));
        chk("adj_en",  32'(adj_en),  32'(m_adj_en));
        chk("adj_sel", 32'(adj_sel), 32'(m_adj_sel));
        chk("clr",     32'(clr),     32'(m_clr));
        chk("running", 32'(running), 32'(!m_paused));
        chk("blink",   32'(blink),   32'(m_blink));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn_pause = 1'b0; btn_clear = 1'b0;
        adjust = 1'b0; select = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int pulses[$];
    int cnt, tog, kc, kn, nclr, found;
    logic prev_b, prev_r;

    initial begin
        // 1: idle run, reset values and count tick phase
        do_reset();
        chk("rst_running", 32'(running), 32'd1);
        chk("rst_cnt_en",  32'(cnt_en),  32'd0);
        chk("rst_clr",     32'(clr),     32'd0);
        chk("rst_blink",   32'(blink),   32'd0);
        chk("rst_adj_sel", 32'(adj_sel), 32'd0);
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (cnt_en) pulses.push_back(k);
            if (adj_en) cnt++;
        end
        chk("s1_npulse", 32'(pulses.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("s1_tick", (i < pulses.size()) ? 32'(pulses[i]) : 32'd0,
                32'(8 * (i + 1)));
        chk("s1_adj_en", 32'(cnt), 32'd0);

        // 2: long pause press, then a second press
        do_reset();
        btn_pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == LAT - 1) chk("s2_pre", 32'(running), 32'd1);
            if (k == LAT) chk("s2_fall", 32'(running), 32'd0);
        end
        btn_pause = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cnt_en) cnt++;
        end
        chk("s2_no_cnt", 32'(cnt), 32'd0);
        btn_pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == LAT - 1) chk("s2_pre2", 32'(running), 32'd0);
            if (k == LAT) chk("s2_rise", 32'(running), 32'd1);
        end
        btn_pause = 1'b0;

        // 3: two-cycle glitch on pause
        do_reset();
        btn_pause = 1'b1;
        tick();
        tick();
        btn_pause = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("s3_glitch", 32'(running), DEB_ON ? 32'd1 : 32'd0);

        // 4: adjust mode on seconds
        do_reset();
        adjust = 1'b1;
        select = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("s4_adj_sel", 32'(adj_sel), 32'd1);
        cnt = 0; kn = 0; tog = 0; prev_b = blink;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (adj_en) cnt++;
            if (cnt_en) kn++;
            if (blink != prev_b) tog++;
            prev_b = blink;
        end
        chk("s4_adj_cnt", 32'(cnt), 32'd4);
        chk("s4_cnt_en", 32'(kn), 32'd0);
        chk("s4_blink_tog", 32'(tog), 32'd4);
        adjust = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("s4_blink_off", 32'(blink), 32'd0);

        // 5: clear mid-period restarts the count tick
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        btn_clear = 1'b1;
        kc = -1; kn = -1; nclr = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == LAT + 1) btn_clear = 1'b0;
            if (clr) nclr++;
            if (clr && kc < 0) kc = k;
            else if (kc >= 0 && cnt_en && kn < 0) kn = k;
        end
        chk("s5_clr_lat", 32'(kc), 32'(LAT));
        chk("s5_clr_len", 32'(nclr), 32'd1);
        chk("s5_gap", 32'(kn - kc), 32'd8);
        chk("s5_running", 32'(running), 32'd1);

        // 6: pause and clear together, then reset mid-debounce
        do_reset();
        btn_pause = 1'b1;
        btn_clear = 1'b1;
        found = 0;
        prev_r = running;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == LAT + 1) begin
                btn_pause = 1'b0;
                btn_clear = 1'b0;
            end
            if (clr) begin
                found++;
                chk("s6_run_before", 32'(prev_r), 32'd1);
                chk("s6_run_at_clr", 32'(running), 32'd0);
            end
            prev_r = running;
        end
        chk("s6_clr_seen", 32'(found), 32'd1);
        btn_pause = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b0;
        btn_pause = 1'b0;
        tick();
        tick();
        chk("s6_rst_running", 32'(running), 32'd1);
        chk("s6_rst_clr", 32'(clr), 32'd0);
        chk("s6_rst_cnt_en", 32'(cnt_en), 32'd0);
        reset = 1'b1;
        nclr = 0; tog = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (clr) nclr++;
            if (!running) tog++;
        end
        chk("s6_no_clr", 32'(nclr), 32'd0);
        chk("s6_no_pause", 32'(tog), 32'd0);

        // random buttons, switches and occasional reset
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 3) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 39) == 0) adjust = ~adjust;
            if ($urandom_range(0, 19) == 0) select = ~select;
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
